// File: rtl/tbird_seq_ctrl.sv
// Tail-light sequencer: step prescaler, sticky request capture, arbitration and registered lamp pattern.
// Define TBIRD_SEQ_CTRL_BRAKE_EN to add the brake input and its steady-lamp overlay.
module tbird_seq_ctrl #(
  parameter int unsigned TICK_DIV = 4,
  parameter int unsigned TICK_W   = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       left_req,
  input  logic       right_req,
  input  logic       haz_req,
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
  input  logic       brake,
`endif
  output logic [5:0] lights,
  output logic [1:0] mode,
  output logic       step_tick,
  output logic       busy
);

  // state   | meaning
  // ST_IDLE | lamps dark, waiting for a pending request at a step tick
  // ST_S1   | first lamp step of the active mode
  // ST_S2   | second lamp step
  // ST_S3   | third lamp step, returns to ST_IDLE on the next tick
  typedef enum logic [1:0] {ST_IDLE, ST_S1, ST_S2, ST_S3} state_t;

  localparam logic [1:0]        MODE_IDLE  = 2'b00;
  localparam logic [1:0]        MODE_LEFT  = 2'b01;
  localparam logic [1:0]        MODE_RIGHT = 2'b10;
  localparam logic [1:0]        MODE_HAZ   = 2'b11;
  localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [1:0]          r_mode;
  logic [1:0]          w_mode_nxt;
  logic [TICK_W-1:0]   r_cnt;
  logic [2:0]          r_pending;
  logic [2:0]          w_consume;
  logic [5:0]          r_lights;
  logic [5:0]          w_lights_nxt;
  logic [2:0]          w_lfill;
  logic [2:0]          w_rfill;
  logic                r_busy;
  logic                w_tick;

  assign w_tick    = (r_cnt == TICK_LAST);
  assign step_tick = w_tick;
  assign lights    = r_lights;
  assign mode      = r_mode;
  assign busy      = r_busy;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else if (!en) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // pending = {haz, left, right}; a turn in progress can still be pre-empted by hazard
  always_comb begin
    w_state_nxt = r_state;
    w_mode_nxt  = r_mode;
    w_consume   = 3'b000;
    if (w_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (r_pending[2] || (r_pending[1] && r_pending[0])) begin
            w_state_nxt = ST_S1;
            w_mode_nxt  = MODE_HAZ;
            w_consume   = 3'b111;
          end else if (r_pending[1]) begin
            w_state_nxt = ST_S1;
            w_mode_nxt  = MODE_LEFT;
            w_consume   = 3'b010;
          end else if (r_pending[0]) begin
            w_state_nxt = ST_S1;
            w_mode_nxt  = MODE_RIGHT;
            w_consume   = 3'b001;
          end
        end
        default: begin
          if (r_mode != MODE_HAZ && r_pending[2]) begin
            w_state_nxt = ST_S1;
            w_mode_nxt  = MODE_HAZ;
            w_consume   = 3'b111;
          end else begin
            case (r_state)
              ST_S1:   w_state_nxt = ST_S2;
              ST_S2:   w_state_nxt = ST_S3;
              default: begin
                w_state_nxt = ST_IDLE;
                w_mode_nxt  = MODE_IDLE;
              end
            endcase
          end
        end
      endcase
    end
  end

  // Lamps fill outward from the centre: la/ra first, lc/rc last.
  always_comb begin
    w_lfill = 3'b000;
    w_rfill = 3'b000;
    case (w_state_nxt)
      ST_S1: begin
        w_lfill = 3'b001;
        w_rfill = 3'b100;
      end
      ST_S2: begin
        w_lfill = 3'b011;
        w_rfill = 3'b110;
      end
      ST_S3: begin
        w_lfill = 3'b111;
        w_rfill = 3'b111;
      end
      default: ;
    endcase
    w_lights_nxt = {w_mode_nxt[0] ? w_lfill : 3'b000,
                    w_mode_nxt[1] ? w_rfill : 3'b000};
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
    if (brake) begin
      case (w_mode_nxt)
        MODE_IDLE:  w_lights_nxt = w_lights_nxt | 6'b111111;
        MODE_LEFT:  w_lights_nxt = w_lights_nxt | 6'b000111;
        MODE_RIGHT: w_lights_nxt = w_lights_nxt | 6'b111000;
        default:    ;
      endcase
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt     <= '0;
      r_mode    <= MODE_IDLE;
      r_busy    <= 1'b0;
      r_pending <= 3'b000;
      r_lights  <= 6'b000000;
    end else if (!en) begin
      r_cnt     <= '0;
      r_mode    <= MODE_IDLE;
      r_busy    <= 1'b0;
      r_pending <= 3'b000;
      r_lights  <= 6'b000000;
    end else begin
      r_cnt     <= w_tick ? '0 : r_cnt + TICK_W'(1);
      r_mode    <= w_mode_nxt;
      r_busy    <= (w_mode_nxt != MODE_IDLE);
      r_pending <= (r_pending & ~w_consume) | {haz_req, left_req, right_req};
      r_lights  <= w_lights_nxt;
    end
  end

endmodule

// File: tb/tb_tbird_seq_ctrl.sv
// Self-checking bench for tbird_seq_ctrl: directed scenarios plus random stimulus against a step-level model.
module tb_tbird_seq_ctrl;

  localparam int DIV = 4;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] step;
    logic [1:0] mode;
    logic [2:0] pend;
    logic [5:0] lights;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       left_req = 1'b0;
  logic       right_req = 1'b0;
  logic       haz_req = 1'b0;
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
  logic       brake = 1'b0;
`endif
  logic [5:0] lights;
  logic [1:0] mode;
  logic       step_tick;
  logic       busy;

  int         n_vec = 0;
  int         n_err = 0;
  mstate_t    m = '0;

  tbird_seq_ctrl #(.TICK_DIV(DIV), .TICK_W(25)) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .left_req  (left_req),
    .right_req (right_req),
    .haz_req   (haz_req),
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
    .brake     (brake),
`endif
    .lights    (lights),
    .mode      (mode),
    .step_tick (step_tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Reference: one step of the sequence per prescaler wrap, lamp count = step number.
  function automatic mstate_t model_step(mstate_t s, logic enb, logic [2:0] req);
    mstate_t    n;
    logic [2:0] used;
    logic [1:0] start;
    logic [2:0] lf;
    logic [2:0] rf;
    logic       tick;
    n = '0;
    if (!enb) return n;
    n     = s;
    used  = 3'b000;
    start = 2'b00;
    tick  = (int'(s.cnt) == DIV - 1);
    if (tick) begin
      if (s.pend[2] && s.mode != 2'b11) start = 2'b11;
      else if (s.step == 0 && s.pend[1] && s.pend[0]) start = 2'b11;
      else if (s.step == 0 && s.pend[1]) start = 2'b01;
      else if (s.step == 0 && s.pend[0]) start = 2'b10;
      if (start != 2'b00) begin
        n.mode = start;
        n.step = 2'd1;
        used   = (start == 2'b11) ? 3'b111 : ((start == 2'b01) ? 3'b010 : 3'b001);
      end else if (s.step == 2'd3) begin
        n.step = 2'd0;
        n.mode = 2'b00;
      end else if (s.step != 2'd0) begin
        n.step = 2'(s.step + 2'd1);
      end
    end
    n.pend = (s.pend & ~used) | req;
    n.cnt  = tick ? 8'd0 : 8'(s.cnt + 8'd1);
    lf = 3'((1 << n.step) - 1);
    rf = 3'((7 << (3 - n.step)) & 7);
    n.lights = {n.mode[0] ? lf : 3'b000, n.mode[1] ? rf : 3'b000};
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
    if (brake) begin
      case (n.mode)
        2'b00:   n.lights = n.lights | 6'b111111;
        2'b01:   n.lights = n.lights | 6'b000111;
        2'b10:   n.lights = n.lights | 6'b111000;
        default: ;
      endcase
    end
`endif
    return n;
  endfunction

  function automatic logic [9:0] exp_vec();
    return {m.lights, m.mode, (int'(m.cnt) == DIV - 1), (m.mode != 2'b00)};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) m <= '0;
    else      m <= model_step(m, en, {haz_req, left_req, right_req});
  end

  task automatic idle_wait(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (m.step == 2'd0 && m.pend == 3'b000 && m.mode == 2'b00) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    logic [7:0] seen;
    bit         hit;
    rst = 1'b0;
    en  = 1'b1;
    #13;
    n_vec++;
    if ({lights, mode, step_tick, busy} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_init: got %b want %b", {lights, mode, step_tick, busy}, 10'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    left_req = 1'b1;
    @(negedge clk);
    left_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL rst_pre: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (lights != 6'b0) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!hit) begin
      n_err++;
      $display("FAIL rst_pre_timeout: got dark lamps want a running sequence");
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    n_vec++;
    if ({lights, mode, step_tick, busy} !== 10'd0) begin
      n_err++;
      $display("FAIL rst_async: got %b want %b", {lights, mode, step_tick, busy}, 10'd0);
    end
    @(negedge clk);
    rst = 1'b1;
    seen[0] = step_tick;
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL rst_post: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      seen[i] = step_tick;
    end
    n_vec++;
    if (seen !== 8'b1000_1000) begin
      n_err++;
      $display("FAIL tick_period: got %b want %b", seen, 8'b1000_1000);
    end
  endtask

  task automatic test_left();
    logic [5:0]  chg[$];
    logic [5:0]  prev;
    logic [23:0] got;
    int          busy_cyc;
    bit          ok;
    idle_wait(ok);
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL left_idle: got busy want idle");
    end
    left_req = 1'b1;
    prev     = lights;
    busy_cyc = 0;
    for (int i = 0; i < 28; i++) begin
      @(negedge clk);
      left_req = 1'b0;
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL left_cyc: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (busy) busy_cyc++;
      if (lights !== prev) begin
        chg.push_back(lights);
        prev = lights;
      end
    end
    got = '0;
    for (int i = 0; i < 4 && i < chg.size(); i++) got[23-6*i -: 6] = chg[i];
    n_vec++;
    if (chg.size() != 4 || got !== 24'b001000_011000_111000_000000) begin
      n_err++;
      $display("FAIL left_seq: got %0d changes %b want 4 changes %b", chg.size(), got,
               24'b001000_011000_111000_000000);
    end
    n_vec++;
    if (busy_cyc != 12) begin
      n_err++;
      $display("FAIL left_busy: got %0d want 12", busy_cyc);
    end
  endtask

  task automatic test_override();
    logic [5:0]  chg[$];
    logic [5:0]  prev;
    logic [23:0] got;
    bit          ok;
    bit          hit;
    idle_wait(ok);
    left_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      left_req = 1'b0;
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL ovr_pre: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (lights == 6'b011000) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!hit || !ok) begin
      n_err++;
      $display("FAIL ovr_s2_timeout: got %b want 011000", lights);
    end
    haz_req = 1'b1;
    prev    = lights;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      haz_req = 1'b0;
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL ovr_cyc: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (lights !== prev) begin
        chg.push_back(lights);
        prev = lights;
      end
    end
    got = '0;
    for (int i = 0; i < 4 && i < chg.size(); i++) got[23-6*i -: 6] = chg[i];
    n_vec++;
    if (chg.size() != 4 || got !== 24'b001100_011110_111111_000000) begin
      n_err++;
      $display("FAIL ovr_seq: got %0d changes %b want 4 changes %b", chg.size(), got,
               24'b001100_011110_111111_000000);
    end
  endtask

  task automatic test_simul();
    logic [5:0]  chg[$];
    logic [5:0]  prev;
    logic [23:0] got;
    int          bad;
    bit          ok;
    idle_wait(ok);
    left_req  = 1'b1;
    right_req = 1'b1;
    prev = lights;
    bad  = ok ? 0 : 1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      left_req  = 1'b0;
      right_req = 1'b0;
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL simul_cyc: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (mode == 2'b01 || mode == 2'b10) bad++;
      if (lights !== prev) begin
        chg.push_back(lights);
        prev = lights;
      end
    end
    got = '0;
    for (int i = 0; i < 4 && i < chg.size(); i++) got[23-6*i -: 6] = chg[i];
    n_vec++;
    if (bad != 0 || chg.size() != 4 || got !== 24'b001100_011110_111111_000000) begin
      n_err++;
      $display("FAIL simul_seq: got %0d changes %b (%0d turn cycles) want hazard %b", chg.size(),
               got, bad, 24'b001100_011110_111111_000000);
    end
  endtask

  task automatic test_hold_right();
    logic [5:0]  chg[$];
    logic [5:0]  prev;
    logic [23:0] got;
    int          starts;
    int          bad;
    bit          ok;
    idle_wait(ok);
    right_req = 1'b1;
    prev   = lights;
    starts = 0;
    bad    = ok ? 0 : 1;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL hold_cyc: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (mode == 2'b01 || mode == 2'b11) bad++;
      if (lights !== prev) begin
        chg.push_back(lights);
        if (lights == 6'b000100) starts++;
        prev = lights;
      end
    end
    right_req = 1'b0;
    got = '0;
    for (int i = 0; i < 4 && i < chg.size(); i++) got[23-6*i -: 6] = chg[i];
    n_vec++;
    if (starts < 2 || bad != 0 || got !== 24'b000100_000110_000111_000000) begin
      n_err++;
      $display("FAIL hold_seq: got %0d starts %b, %0d bad-mode cycles want >=2 starts %b",
               starts, got, bad, 24'b000100_000110_000111_000000);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    bit hit;
    int bad;
    idle_wait(ok);
    haz_req = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      haz_req = 1'b0;
      if (lights == 6'b011110) begin
        hit = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!hit || !ok) begin
      n_err++;
      $display("FAIL en_s2_timeout: got %b want 011110", lights);
    end
    left_req = 1'b1;
    @(negedge clk);
    left_req = 1'b0;
    en       = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({lights, mode, step_tick, busy} !== 10'd0) begin
      n_err++;
      $display("FAIL en_off: got %b want %b", {lights, mode, step_tick, busy}, 10'd0);
    end
    bad = 0;
    repeat (5) begin
      @(negedge clk);
      if (step_tick !== 1'b0 || lights !== 6'b0) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL en_hold: got %0d active cycles want 0", bad);
    end
    en  = 1'b1;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL en_cyc: got %b want %b", {lights, mode, step_tick, busy}, exp_vec());
      end
      if (mode != 2'b00) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL en_pending_lost: got %0d busy cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      n_vec++;
      if ({lights, mode, step_tick, busy} !== exp_vec()) begin
        n_err++;
        $display("FAIL rand_cyc%0d: got %b want %b", i, {lights, mode, step_tick, busy}, exp_vec());
      end
      left_req  = ($urandom_range(0, 15) == 0);
      right_req = ($urandom_range(0, 15) == 0);
      haz_req   = ($urandom_range(0, 29) == 0);
      en        = ($urandom_range(0, 79) != 0);
`ifdef TBIRD_SEQ_CTRL_BRAKE_EN
      brake     = ($urandom_range(0, 3) == 0);
`endif
    end
    left_req  = 1'b0;
    right_req = 1'b0;
    haz_req   = 1'b0;
    en        = 1'b1;
  endtask

  initial begin
    test_reset();
    test_left();
    test_override();
    test_simul();
    test_hold_right();
    test_en_drop();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
